// File: rtl/goldschmidt_ctrl.sv
// rtl/goldschmidt_ctrl.sv - Goldschmidt divider control FSM
// Sequences N0, D0, then ITER (NI, DI) pairs, each held for MUL_LAT cycles.
module goldschmidt_ctrl #(
  parameter int ITER    = 3,
  parameter int MUL_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [1:0] sel_ND_mux,
  output logic       sel_K_mux,
  output logic       load_regN,
  output logic       load_regD,
  output logic       busy,
  output logic       done
);

  localparam int SW = $clog2(MUL_LAT + 1);
  localparam int IW = $clog2(ITER + 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(MUL_LAT - 1);
  localparam logic [IW-1:0] ITER_LAST = IW'(ITER);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_N0   = 3'd1;
  localparam logic [2:0] S_D0   = 3'd2;
  localparam logic [2:0] S_NI   = 3'd3;
  localparam logic [2:0] S_DI   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]    state, state_nx;
  logic [SW-1:0] step, step_nx;
  logic [IW-1:0] iter, iter_nx;

  always_comb begin
    state_nx = state;
    step_nx  = step;
    iter_nx  = iter;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_N0;
          step_nx  = '0;
          iter_nx  = '0;
        end
      end
      S_N0, S_D0, S_NI, S_DI: begin
        if (step == STEP_LAST) begin
          step_nx = '0;
          case (state)
            S_N0:    state_nx = S_D0;
            S_D0:    state_nx = S_NI;
            S_NI:    state_nx = S_DI;
            default: begin
              iter_nx  = iter + IW'(1);
              state_nx = (iter + IW'(1) == ITER_LAST) ? S_DONE : S_NI;
            end
          endcase
        end else begin
          step_nx = step + SW'(1);
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      step  <= '0;
      iter  <= '0;
    end else begin
      state <= state_nx;
      step  <= step_nx;
      iter  <= iter_nx;
    end
  end

  // Outputs are registered from the next-state decode so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_ND_mux <= 2'b00;
      sel_K_mux  <= 1'b0;
      load_regN  <= 1'b0;
      load_regD  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      sel_ND_mux <= 2'b00;
      sel_K_mux  <= 1'b0;
      load_regN  <= 1'b0;
      load_regD  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      case (state_nx)
        S_N0: begin
          busy      <= 1'b1;
          load_regN <= (step_nx == STEP_LAST);
        end
        S_D0: begin
          busy       <= 1'b1;
          sel_ND_mux <= 2'b01;
          load_regD  <= (step_nx == STEP_LAST);
        end
        S_NI: begin
          busy       <= 1'b1;
          sel_ND_mux <= 2'b10;
          sel_K_mux  <= 1'b1;
          load_regN  <= (step_nx == STEP_LAST);
        end
        S_DI: begin
          busy       <= 1'b1;
          sel_ND_mux <= 2'b11;
          sel_K_mux  <= 1'b1;
          load_regD  <= (step_nx == STEP_LAST);
        end
        S_DONE:  done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_goldschmidt_ctrl.sv
// tb/tb_goldschmidt_ctrl.sv - directed bench for goldschmidt_ctrl
// Output vector is {sel_ND_mux, sel_K_mux, load_regN, load_regD, busy, done}.
module tb_goldschmidt_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  logic [1:0] sel_a, sel_b;
  logic       k_a, k_b, ln_a, ln_b, ld_a, ld_b, busy_a, busy_b, done_a, done_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  goldschmidt_ctrl #(.ITER(3), .MUL_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .sel_ND_mux(sel_a), .sel_K_mux(k_a), .load_regN(ln_a), .load_regD(ld_a),
    .busy(busy_a), .done(done_a)
  );

  goldschmidt_ctrl #(.ITER(2), .MUL_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .sel_ND_mux(sel_b), .sel_K_mux(k_b), .load_regN(ln_b), .load_regD(ld_b),
    .busy(busy_b), .done(done_b)
  );

  wire [6:0] obs_a = {sel_a, k_a, ln_a, ld_a, busy_a, done_a};
  wire [6:0] obs_b = {sel_b, k_b, ln_b, ld_b, busy_b, done_b};

  // Q1.15 datapath driven by dut_a, 2.0 represented as 0x10000.
  logic [31:0] regn, regd;
  logic [31:0] opnd, kfac;
  logic [63:0] prod;
  localparam logic [31:0] N_IN = 32'h8000, D_IN = 32'hC000, IA = 32'h5800;

  always_comb begin
    case (sel_a)
      2'b00:   opnd = N_IN;
      2'b01:   opnd = D_IN;
      2'b10:   opnd = regn;
      default: opnd = regd;
    endcase
    kfac = k_a ? (32'h10000 - regd) : IA;
    prod = (64'(opnd) * 64'(kfac)) >> 15;
  end

  always @(posedge clk) begin
    if (ln_a) regn <= prod[31:0];
    if (ld_a) regd <= prod[31:0];
  end

  // Expected outputs in cycle c of a division (c=1 first N0 cycle).
  function automatic logic [6:0] exp_vec(int c, int it, int lat);
    int total, s, ph;
    logic [1:0] sel;
    logic ld;
    total = (2 + 2 * it) * lat;
    if (c < 1 || c > total + 1) return 7'b0;
    if (c == total + 1) return 7'b0000001;
    s  = (c - 1) / lat;
    ph = (c - 1) % lat;
    sel = (s == 0) ? 2'b00 : (s == 1) ? 2'b01 : ((s % 2) == 0) ? 2'b10 : 2'b11;
    ld = (ph == lat - 1);
    return {sel, (s >= 2), ld && (s % 2 == 0), ld && (s % 2 == 1), 1'b1, 1'b0};
  endfunction

  task automatic test_reset;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (obs_a !== 7'b0 || obs_b !== 7'b0) begin
        n_err++;
        $display("FAIL reset_hold cyc%0d: a=%b b=%b expected 0000000", i, obs_a, obs_b);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if (obs_a !== 7'b0 || obs_b !== 7'b0) begin
        n_err++;
        $display("FAIL idle cyc%0d: a=%b b=%b expected 0000000", i, obs_a, obs_b);
      end
    end
  endtask

  task automatic test_default;
    start_a = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      n_vec++;
      if (obs_a !== exp_vec(c, 3, 1)) begin
        n_err++;
        $display("FAIL default cyc%0d: got %b expected %b", c, obs_a, exp_vec(c, 3, 1));
      end
    end
  endtask

  task automatic test_latency;
    start_b = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      n_vec++;
      if (obs_b !== exp_vec(c, 2, 3)) begin
        n_err++;
        $display("FAIL latency cyc%0d: got %b expected %b", c, obs_b, exp_vec(c, 2, 3));
      end
    end
  endtask

  task automatic test_start_pulses;
    start_a = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start_a = (c == 3 || c == 9);
      n_vec++;
      if (obs_a !== exp_vec(c, 3, 1)) begin
        n_err++;
        $display("FAIL start_pulse cyc%0d: got %b expected %b", c, obs_a, exp_vec(c, 3, 1));
      end
    end
    start_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start_held;
    logic [6:0] e;
    start_a = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 11) start_a = 1'b0;
      e = (c <= 10) ? exp_vec(c, 3, 1) : exp_vec(c - 10, 3, 1);
      n_vec++;
      if (obs_a !== e) begin
        n_err++;
        $display("FAIL start_held cyc%0d: got %b expected %b", c, obs_a, e);
      end
    end
  endtask

  task automatic test_reset_midop;
    start_a = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      n_vec++;
      if (obs_a !== exp_vec(c, 3, 1)) begin
        n_err++;
        $display("FAIL midop_pre cyc%0d: got %b expected %b", c, obs_a, exp_vec(c, 3, 1));
      end
    end
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (obs_a !== 7'b0) begin
      n_err++;
      $display("FAIL midop_async: got %b expected 0000000", obs_a);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 1) reset = 1'b1;
      n_vec++;
      if (obs_a !== 7'b0) begin
        n_err++;
        $display("FAIL midop_nodone cyc%0d: got %b expected 0000000", i, obs_a);
      end
    end
    test_default();
  endtask

  task automatic test_datapath;
    int diff;
    bit seen;
    seen = 1'b0;
    start_a = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (done_a) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL datapath_done: got no done within 40 cycles expected done");
    end else begin
      diff = int'(regn) - 32'h5555;
      if (diff > 2 || diff < -2) begin
        n_err++;
        $display("FAIL datapath_quot: got %h expected 5555 +/-2", regn);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_default();
    test_latency();
    test_start_pulses();
    test_start_held();
    test_reset_midop();
    test_datapath();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
